uart_word_rx: RTL and testbench

UART_WORD_RX -- requirements
Module: uart_word_rx

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_word_rx_if.sv | 15 +
 rtl/uart_rx_byte.sv | 115 +++++++++++
 rtl/uart_word_rx.sv | 89 ++++++++
 tb/tb_uart_word_rx.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Constants and byte-FSM encoding used by both the UART receiver and the transmitter.
package uart_pkg;
  localparam int DIVISOR      = 79;
  localparam int DVSR_BIT     = 7;
  localparam int ADDR_W       = 9;
  localparam int TIMEOUT_BITS = 20;
  localparam int WORD_BYTES   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_t;
endpackage

// File: rtl/uart_word_rx_if.sv
// Word-write bus from the receiver to a RAM-style consumer, plus status and FSM debug.
// Handshake: wr_ram is a one-cycle fire-and-forget strobe, data_out/address are valid
// in that cycle; there is no ready, so the slave must accept a write on any cycle.
interface uart_word_rx_if #(parameter int ADDR_W = uart_pkg::ADDR_W);
  import uart_pkg::*;
  logic [31:0]       data_out;
  logic [ADDR_W-1:0] address;
  logic              wr_ram;
  logic              frame_err;
  logic              busy;
  rx_state_t         state;

  modport master (output data_out, address, wr_ram, frame_err, busy, state);
  modport slave  (input  data_out, address, wr_ram, frame_err, busy, state);
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: rx synchronizer, free-running 16x tick generator and byte FSM.
module uart_rx_byte #(
  parameter int DIVISOR  = uart_pkg::DIVISOR,
  parameter int DVSR_BIT = uart_pkg::DVSR_BIT
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_rx,
  output logic [7:0]          o_byte,
  output logic                o_byte_valid,
  output logic                o_frame_err,
  output logic                o_tick,
  output logic                o_start,
  output uart_pkg::rx_state_t o_state
);
  import uart_pkg::*;

  localparam logic [DVSR_BIT-1:0] DIV_LAST = DVSR_BIT'(DIVISOR - 1);

  logic [1:0]          r_sync;
  logic [DVSR_BIT-1:0] r_div;
  rx_state_t           r_state, w_state_n;
  logic [3:0]          r_scnt, w_scnt_n;
  logic [2:0]          r_bit, w_bit_n;
  logic [7:0]          r_shift, w_shift_n;
  logic                w_rx, w_tick;
  logic                w_valid, w_ferr, w_start;

  assign w_rx   = r_sync[1];
  assign w_tick = (r_div == DIV_LAST);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync  <= 2'b11;
      r_div   <= '0;
      r_state <= ST_IDLE;
      r_scnt  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_sync  <= {r_sync[0], i_rx};
      r_div   <= w_tick ? '0 : r_div + 1'b1;
      r_state <= w_state_n;
      r_scnt  <= w_scnt_n;
      r_bit   <= w_bit_n;
      r_shift <= w_shift_n;
    end
  end

  // Samples land mid-bit: tick 7 of the start bit, then every 16 ticks.
  always_comb begin
    w_state_n = r_state;
    w_scnt_n  = r_scnt;
    w_bit_n   = r_bit;
    w_shift_n = r_shift;
    w_valid   = 1'b0;
    w_ferr    = 1'b0;
    w_start   = 1'b0;
    if (w_tick) begin
      case (r_state)
        ST_IDLE: begin
          if (!w_rx) begin
            w_state_n = ST_START;
            w_scnt_n  = '0;
            w_start   = 1'b1;
          end
        end
        ST_START: begin
          if (r_scnt == 4'd7) begin
            w_scnt_n  = '0;
            w_bit_n   = '0;
            w_state_n = w_rx ? ST_IDLE : ST_DATA;
          end else begin
            w_scnt_n = r_scnt + 4'd1;
          end
        end
        ST_DATA: begin
          if (r_scnt == 4'd15) begin
            w_scnt_n  = '0;
            w_shift_n = {w_rx, r_shift[7:1]};
            if (r_bit == 3'd7) w_state_n = ST_STOP;
            else               w_bit_n   = r_bit + 3'd1;
          end else begin
            w_scnt_n = r_scnt + 4'd1;
          end
        end
        ST_STOP: begin
          if (r_scnt == 4'd15) begin
            w_scnt_n = '0;
            if (w_rx) begin
              w_valid   = 1'b1;
              w_state_n = ST_IDLE;
            end else begin
              w_ferr    = 1'b1;
              w_state_n = ST_WAIT_IDLE;
            end
          end else begin
            w_scnt_n = r_scnt + 4'd1;
          end
        end
        ST_WAIT_IDLE: begin
          if (w_rx) w_state_n = ST_IDLE;
        end
        default: w_state_n = ST_IDLE;
      endcase
    end
  end

  assign o_byte       = r_shift;
  assign o_byte_valid = w_valid;
  assign o_frame_err  = w_ferr;
  assign o_tick       = w_tick;
  assign o_start      = w_start;
  assign o_state      = r_state;
endmodule

// File: rtl/uart_word_rx.sv
// Assembles received bytes little-endian into 32-bit words and emits addressed RAM writes,
// discarding partial words on frame errors and on line-idle timeout.
module uart_word_rx #(
  parameter int DIVISOR      = uart_pkg::DIVISOR,
  parameter int DVSR_BIT     = uart_pkg::DVSR_BIT,
  parameter int ADDR_W       = uart_pkg::ADDR_W,
  parameter int TIMEOUT_BITS = uart_pkg::TIMEOUT_BITS
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           rx,
  uart_word_rx_if.master word_if
);
  import uart_pkg::*;

  localparam int              TO_TICKS  = 16 * TIMEOUT_BITS;
  localparam int              TO_W      = $clog2(TO_TICKS + 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TO_TICKS - 1);
  localparam logic [1:0]      LAST_BYTE = 2'(WORD_BYTES - 1);

  logic [7:0]        w_byte;
  logic              w_byte_valid, w_frame_err, w_tick, w_start;
  rx_state_t         w_state;
  logic              w_idle_hold, w_timeout;

  logic [1:0]        r_byte_cnt;
  logic [23:0]       r_word;
  logic [31:0]       r_data;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wr, r_ferr;
  logic [TO_W-1:0]   r_to;

  uart_rx_byte #(.DIVISOR(DIVISOR), .DVSR_BIT(DVSR_BIT)) u_byte (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_rx         (rx),
    .o_byte       (w_byte),
    .o_byte_valid (w_byte_valid),
    .o_frame_err  (w_frame_err),
    .o_tick       (w_tick),
    .o_start      (w_start),
    .o_state      (w_state)
  );

  // A start edge on the expiry tick wins, so the new byte joins the held word.
  assign w_idle_hold = (w_state == ST_IDLE) && (r_byte_cnt != 2'd0);
  assign w_timeout   = w_idle_hold && w_tick && !w_start && (r_to == TO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_byte_cnt <= '0;
      r_word     <= '0;
      r_data     <= '0;
      r_addr     <= '0;
      r_wr       <= 1'b0;
      r_ferr     <= 1'b0;
      r_to       <= '0;
    end else begin
      r_wr   <= 1'b0;
      r_ferr <= w_frame_err;
      if (r_wr) r_addr <= r_addr + 1'b1;
      if (w_byte_valid) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
        if (r_byte_cnt == LAST_BYTE) begin
          r_data <= {w_byte, r_word};
          r_wr   <= 1'b1;
        end else begin
          case (r_byte_cnt)
            2'd0:    r_word[7:0]   <= w_byte;
            2'd1:    r_word[15:8]  <= w_byte;
            default: r_word[23:16] <= w_byte;
          endcase
        end
      end else if (w_frame_err || w_timeout) begin
        r_byte_cnt <= '0;
        r_word     <= '0;
      end
      if (!w_idle_hold || w_start || w_timeout) r_to <= '0;
      else if (w_tick)                          r_to <= r_to + 1'b1;
    end
  end

  assign word_if.data_out  = r_data;
  assign word_if.address   = r_addr;
  assign word_if.wr_ram    = r_wr;
  assign word_if.frame_err = r_ferr;
  assign word_if.busy      = (w_state != ST_IDLE) || (r_byte_cnt != 2'd0);
  assign word_if.state     = w_state;
endmodule

// File: tb/tb_uart_word_rx.sv
// Directed bench for uart_word_rx: serial 8N1 driver, write monitor and per-scenario checks.
module tb_uart_word_rx;
  import uart_pkg::*;

  localparam int DIV = 4;
  localparam int AW  = 3;
  localparam int TOB = 20;
  localparam int BIT = 16 * DIV;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic rx    = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;

  logic [AW+31:0] exp_q[$];
  logic [AW+31:0] got_q[$];
  logic [AW:0]    after_q[$];
  int             fe_cycles = 0;
  logic           prev_wr = 1'b0;
  logic [AW-1:0]  exp_addr = '0;

  uart_word_rx_if #(.ADDR_W(AW)) wbus ();

  uart_word_rx #(.DIVISOR(DIV), .DVSR_BIT(3), .ADDR_W(AW), .TIMEOUT_BITS(TOB)) dut (
    .clk     (clk),
    .reset   (reset),
    .rx      (rx),
    .word_if (wbus)
  );

  always #5 clk = ~clk;

  // Monitor: records each write and, one cycle later, {wr_ram, address}.
  always @(negedge clk) begin
    if (prev_wr) after_q.push_back({wbus.wr_ram, wbus.address});
    if (wbus.wr_ram) got_q.push_back({wbus.address, wbus.data_out});
    if (wbus.frame_err) fe_cycles++;
    prev_wr = wbus.wr_ram;
  end

  task automatic send_byte(input logic [7:0] d, input logic stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop;
    repeat (BIT) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b1);
  endtask

  task automatic expect_word(input logic [31:0] w);
    exp_q.push_back({exp_addr, w});
    exp_addr = exp_addr + 1'b1;
  endtask

  task automatic test_reset();
    repeat (5) @(negedge clk);
    n_cmp++; if (wbus.data_out !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h required 0", wbus.data_out); end
    n_cmp++; if (wbus.address !== '0) begin n_fail++; $display("FAIL reset_addr: got %0d required 0", wbus.address); end
    n_cmp++; if (wbus.wr_ram !== 1'b0) begin n_fail++; $display("FAIL reset_wr: got %b required 0", wbus.wr_ram); end
    n_cmp++; if (wbus.frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b required 0", wbus.frame_err); end
    n_cmp++; if (wbus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", wbus.busy); end
    reset = 1'b0;
    repeat (3 * BIT) @(negedge clk);
    n_cmp++; if (wbus.state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d required IDLE", wbus.state); end
  endtask

  task automatic test_single_word();
    logic [AW+31:0] e, g;
    logic [AW:0]    a;
    expect_word(32'h12345678);
    send_word(32'h12345678);
    repeat (4) @(negedge clk);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() != 0) ? got_q.pop_front() : 'x;
      n_cmp++; if (g !== e) begin n_fail++; $display("FAIL single_word: {addr,data} got %h required %h", g, e); end
      a = (after_q.size() != 0) ? after_q.pop_front() : 'x;
      n_cmp++; if (a !== {1'b0, e[AW+31:32] + 1'b1}) begin n_fail++; $display("FAIL single_after: {wr,addr} got %h required %h", a, {1'b0, e[AW+31:32] + 1'b1}); end
    end
    n_cmp++; if (wbus.address !== 3'd1) begin n_fail++; $display("FAIL single_addr_now: got %0d required 1", wbus.address); end
    n_cmp++; if (got_q.size() != 0) begin n_fail++; $display("FAIL single_extra: got %0d extra writes required 0", got_q.size()); end
  endtask

  task automatic test_frame_err();
    logic [AW+31:0] e, g;
    int fe0;
    fe0 = fe_cycles;
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'hAA, 1'b0);
    repeat (2 * BIT) @(negedge clk);
    n_cmp++; if (fe_cycles - fe0 != 1) begin n_fail++; $display("FAIL ferr_pulse: got %0d cycles required 1", fe_cycles - fe0); end
    n_cmp++; if (got_q.size() != 0) begin n_fail++; $display("FAIL ferr_nowrite: got %0d writes required 0", got_q.size()); end
    n_cmp++; if (wbus.busy !== 1'b0) begin n_fail++; $display("FAIL ferr_busy: got %b required 0", wbus.busy); end
    expect_word(32'h44332211);
    send_word(32'h44332211);
    repeat (4) @(negedge clk);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() != 0) ? got_q.pop_front() : 'x;
      n_cmp++; if (g !== e) begin n_fail++; $display("FAIL ferr_word: {addr,data} got %h required %h", g, e); end
    end
    after_q.delete();
  endtask

  task automatic test_glitch();
    int fe0;
    fe0 = fe_cycles;
    @(negedge clk);
    rx = 1'b0;
    repeat (2 * DIV) @(negedge clk);
    n_cmp++; if (wbus.busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_hi: got %b required 1", wbus.busy); end
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    n_cmp++; if (wbus.busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_lo: got %b required 0", wbus.busy); end
    n_cmp++; if (fe_cycles != fe0) begin n_fail++; $display("FAIL glitch_ferr: got %0d cycles required 0", fe_cycles - fe0); end
    n_cmp++; if (got_q.size() != 0) begin n_fail++; $display("FAIL glitch_write: got %0d writes required 0", got_q.size()); end
  endtask

  task automatic test_timeout();
    logic [AW+31:0] e, g;
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    repeat (4) @(negedge clk);
    n_cmp++; if (wbus.busy !== 1'b1) begin n_fail++; $display("FAIL timeout_held: busy got %b required 1", wbus.busy); end
    repeat (21 * BIT) @(negedge clk);
    n_cmp++; if (wbus.busy !== 1'b0) begin n_fail++; $display("FAIL timeout_clear: busy got %b required 0", wbus.busy); end
    expect_word(32'hAABBCCDD);
    send_word(32'hAABBCCDD);
    repeat (4) @(negedge clk);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() != 0) ? got_q.pop_front() : 'x;
      n_cmp++; if (g !== e) begin n_fail++; $display("FAIL timeout_word: {addr,data} got %h required %h", g, e); end
    end
    after_q.delete();
  endtask

  task automatic test_reset_mid_word();
    logic [AW+31:0] e, g;
    logic [7:0] b2;
    b2 = 8'h5B;
    send_byte(8'h21, 1'b1);
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      rx = b2[i];
      repeat (BIT) @(negedge clk);
    end
    rx = b2[2];
    repeat (BIT / 2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (wbus.data_out !== 32'h0) begin n_fail++; $display("FAIL rst_mid_data: got %h required 0", wbus.data_out); end
    n_cmp++; if (wbus.address !== '0) begin n_fail++; $display("FAIL rst_mid_addr: got %0d required 0", wbus.address); end
    n_cmp++; if (wbus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b required 0", wbus.busy); end
    n_cmp++; if ({wbus.wr_ram, wbus.frame_err} !== 2'b00) begin n_fail++; $display("FAIL rst_mid_strobes: got %b required 00", {wbus.wr_ram, wbus.frame_err}); end
    rx = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (BIT) @(negedge clk);
    exp_addr = '0;
    expect_word(32'h0BADF00D);
    send_word(32'h0BADF00D);
    repeat (4) @(negedge clk);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() != 0) ? got_q.pop_front() : 'x;
      n_cmp++; if (g !== e) begin n_fail++; $display("FAIL rst_mid_word: {addr,data} got %h required %h", g, e); end
    end
    n_cmp++; if (got_q.size() != 0) begin n_fail++; $display("FAIL rst_mid_extra: got %0d extra writes required 0", got_q.size()); end
    after_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [AW+31:0] e, g;
    logic [AW:0]    a;
    logic [31:0]    w;
    for (int i = 0; i <= (1 << AW); i++) begin
      w = {8'(i), 8'(8'hA0 + i), 8'(8'h5F - i), 8'(3 * i + 1)};
      expect_word(w);
      send_word(w);
    end
    repeat (4) @(negedge clk);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() != 0) ? got_q.pop_front() : 'x;
      n_cmp++; if (g !== e) begin n_fail++; $display("FAIL b2b_word: {addr,data} got %h required %h", g, e); end
      a = (after_q.size() != 0) ? after_q.pop_front() : 'x;
      n_cmp++; if (a !== {1'b0, e[AW+31:32] + 1'b1}) begin n_fail++; $display("FAIL b2b_after: {wr,addr} got %h required %h", a, {1'b0, e[AW+31:32] + 1'b1}); end
    end
    n_cmp++; if (got_q.size() != 0) begin n_fail++; $display("FAIL b2b_extra: got %0d extra writes required 0", got_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_frame_err();
    test_glitch();
    test_timeout();
    test_reset_mid_word();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
